// File: rtl/adc_2ch_sched_if.sv
// SPI write/read engine link: start strobe, command and divider out; result and end-of-conversion back.
interface adc_2ch_sched_if;
  logic        strc;
  logic [7:0]  cmd;
  logic [7:0]  kmax;
  logic [11:0] dout;
  logic        eoc;

  modport master (output strc, output cmd, output kmax, input dout, input eoc);
  modport slave  (input strc, input cmd, input kmax, output dout, output eoc);
endinterface

// File: rtl/adc_2ch_sched.sv
// Two-channel ADC conversion scheduler: frame timer, per-channel start/ack/convert sequence,
// per-channel result holding registers, sticky timeout and overrun flags.
module adc_2ch_sched #(
  parameter logic [7:0]  CMD_CH0 = 8'hD0,
  parameter logic [7:0]  CMD_CH1 = 8'hF0,
  parameter logic [7:0]  KMAX    = 8'd50,
  parameter logic [31:0] PERIOD  = 32'd100000,
  parameter logic [15:0] TIMEOUT = 16'd4095
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [1:0]      ch_mask_i,
  input  logic            clr_i,
  adc_2ch_sched_if.master spi,
  output logic [11:0]     ch0_data_o,
  output logic [11:0]     ch1_data_o,
  output logic            ch0_vld_o,
  output logic            ch1_vld_o,
  output logic            busy_o,
  output logic            err_o,
  output logic            ovr_o
);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_ACK, ST_CONV, ST_GAP} state_t;

  state_t      state_r, state_nxt_s;
  logic [31:0] tmr_r;
  logic        tick_s;
  logic        sel_r, sel_nxt_s;
  logic        ch1_pend_r, ch1_pend_nxt_s;
  logic [15:0] wait_r, wait_nxt_s, wait_inc_s;
  logic        tmo_s, cap_s, ovr_set_s;
  logic        strc_r, busy_r, err_r, ovr_r;
  logic [7:0]  cmd_r;
  logic [11:0] ch0_data_r, ch1_data_r;
  logic        ch0_vld_r, ch1_vld_r;

  assign tick_s     = en_i && (tmr_r == (PERIOD - 32'd1));
  assign wait_inc_s = wait_r + 16'd1;
  assign ovr_set_s  = tick_s && (state_r != ST_IDLE);

  // Frame timer: free-runs while enabled, parked at zero otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmr_r <= 32'd0;
    end else if (!en_i || tick_s) begin
      tmr_r <= 32'd0;
    end else begin
      tmr_r <= tmr_r + 32'd1;
    end
  end

  // Sequencer next state; ch1_pend marks ch1 still owed after ch0 in this frame.
  always_comb begin
    state_nxt_s    = state_r;
    sel_nxt_s      = sel_r;
    ch1_pend_nxt_s = ch1_pend_r;
    wait_nxt_s     = wait_inc_s;
    tmo_s          = 1'b0;
    cap_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tick_s && (ch_mask_i != 2'b00)) begin
          state_nxt_s    = ST_START;
          sel_nxt_s      = ~ch_mask_i[0];
          ch1_pend_nxt_s = ch_mask_i[0] & ch_mask_i[1];
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        state_nxt_s = ST_ACK;
        wait_nxt_s  = 16'd0;
      end
      ST_ACK: begin
        if (!spi.eoc) begin
          state_nxt_s = ST_CONV;
          wait_nxt_s  = 16'd0;
        end else if (wait_inc_s >= TIMEOUT) begin
          state_nxt_s = ST_GAP;
          tmo_s       = 1'b1;
        end else begin
          state_nxt_s = ST_ACK;
        end
      end
      ST_CONV: begin
        if (spi.eoc) begin
          state_nxt_s = ST_GAP;
          cap_s       = 1'b1;
        end else if (wait_inc_s >= TIMEOUT) begin
          state_nxt_s = ST_GAP;
          tmo_s       = 1'b1;
        end else begin
          state_nxt_s = ST_CONV;
        end
      end
      ST_GAP: begin
        if (ch1_pend_r) begin
          state_nxt_s    = ST_START;
          sel_nxt_s      = 1'b1;
          ch1_pend_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and per-frame context.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      sel_r      <= 1'b0;
      ch1_pend_r <= 1'b0;
      wait_r     <= 16'd0;
    end else begin
      state_r    <= state_nxt_s;
      sel_r      <= sel_nxt_s;
      ch1_pend_r <= ch1_pend_nxt_s;
      wait_r     <= wait_nxt_s;
    end
  end

  // Engine strobe/command and result registers, decoded from the next state so they align with it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      strc_r     <= 1'b0;
      busy_r     <= 1'b0;
      cmd_r      <= CMD_CH0;
      ch0_data_r <= 12'd0;
      ch1_data_r <= 12'd0;
      ch0_vld_r  <= 1'b0;
      ch1_vld_r  <= 1'b0;
    end else begin
      strc_r    <= (state_nxt_s == ST_START);
      busy_r    <= (state_nxt_s != ST_IDLE);
      ch0_vld_r <= cap_s && !sel_r;
      ch1_vld_r <= cap_s && sel_r;
      if (state_nxt_s == ST_START) begin
        cmd_r <= sel_nxt_s ? CMD_CH1 : CMD_CH0;
      end
      if (cap_s && !sel_r) begin
        ch0_data_r <= spi.dout;
      end
      if (cap_s && sel_r) begin
        ch1_data_r <= spi.dout;
      end
    end
  end

  // Sticky flags: a set event in the same cycle as clr_i keeps the flag high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_r <= 1'b0;
      ovr_r <= 1'b0;
    end else begin
      if (tmo_s) begin
        err_r <= 1'b1;
      end else if (clr_i) begin
        err_r <= 1'b0;
      end
      if (ovr_set_s) begin
        ovr_r <= 1'b1;
      end else if (clr_i) begin
        ovr_r <= 1'b0;
      end
    end
  end

  assign spi.strc   = strc_r;
  assign spi.cmd    = cmd_r;
  assign spi.kmax   = KMAX;
  assign ch0_data_o = ch0_data_r;
  assign ch1_data_o = ch1_data_r;
  assign ch0_vld_o  = ch0_vld_r;
  assign ch1_vld_o  = ch1_vld_r;
  assign busy_o     = busy_r;
  assign err_o      = err_r;
  assign ovr_o      = ovr_r;

endmodule
